// File: rtl/cl_mbox_pkg.sv
// Shared types and constants for the BAR1 TOHOST/FROMHOST mailbox responder.
// Optional IRQ output is built only when CL_MBOX_IRQ_EN is defined (see top).
package cl_mbox_pkg;

  localparam logic [31:0] DEF_BASE_ADDR  = 32'h0008_C000;
  localparam logic [11:0] DEF_TOHOST_OFS = 12'h120;
  localparam logic [11:0] DEF_FHOST_OFS  = 12'h140;
  localparam logic [11:0] DEF_STAT_OFS   = 12'h160;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_A, WR_HAVE_D, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {REG_TOHOST, REG_FHOST, REG_STAT, REG_NONE} reg_sel_t;

  typedef struct packed {
    logic [15:0] core_wr_cnt;
    logic [13:0] rsvd;
    logic        tohost_nz;
    logic        fromhost_valid;
  } stat_t;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/cl_mbox_axil_wr.sv
// AXI4-Lite write join: AW and W captured independently, one write strobe when both are present,
// then B held until bready. bvalid follows the last of AW/W by one clock.
module cl_mbox_axil_wr
  import cl_mbox_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] awaddr_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic        bvalid_o,
  input  logic        bready_i,
  output logic [1:0]  bresp_o,
  output logic        wr_en_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic [3:0]  wr_strb_o,
  input  logic [1:0]  wr_resp_i
);

  wr_state_t   state_q;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q;
  logic [31:0] addr_q, data_q;
  logic [3:0]  strb_q;
  logic        aw_fire, w_fire, have_a, have_d;

  assign aw_fire = awvalid_i & awready_q;
  assign w_fire  = wvalid_i & wready_q;
  assign have_a  = (state_q == WR_HAVE_A) | aw_fire;
  assign have_d  = (state_q == WR_HAVE_D) | w_fire;

  // Same-cycle handshakes bypass the holding registers so the write lands at that edge.
  assign wr_en_o   = have_a & have_d;
  assign wr_addr_o = aw_fire ? awaddr_i : addr_q;
  assign wr_data_o = w_fire ? wdata_i : data_q;
  assign wr_strb_o = w_fire ? wstrb_i : strb_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= WR_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      if (aw_fire) addr_q <= awaddr_i;
      if (w_fire) begin
        data_q <= wdata_i;
        strb_q <= wstrb_i;
      end
      case (state_q)
        WR_RESP: begin
          if (bready_i) begin
            state_q   <= WR_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: begin
          if (wr_en_o) begin
            state_q   <= WR_RESP;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_resp_i;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end else if (have_a) begin
            state_q   <= WR_HAVE_A;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
          end else if (have_d) begin
            state_q   <= WR_HAVE_D;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
          end else begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;

endmodule

// File: rtl/cl_tohost_mailbox_slv.sv
// BAR1 AXI4-Lite mailbox: TOHOST/FROMHOST/STATUS registers shared between host and soft core.
// Define CL_MBOX_IRQ_EN to add irq_req, raised on core TOHOST writes until the host reads TOHOST.
module cl_tohost_mailbox_slv
  import cl_mbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter logic [11:0] TOHOST_OFS = DEF_TOHOST_OFS,
  parameter logic [11:0] FHOST_OFS  = DEF_FHOST_OFS,
  parameter logic [11:0] STAT_OFS   = DEF_STAT_OFS
) (
  input  logic        clk_main_a0,
  input  logic        rst_main_n,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  input  logic        core_tohost_we,
  input  logic [31:0] core_tohost_wdata,
  output logic [31:0] core_tohost_rdata,
  output logic [31:0] core_fromhost_rdata,
  output logic        core_fromhost_valid,
  input  logic        core_fromhost_ack
`ifdef CL_MBOX_IRQ_EN
  ,
  output logic        irq_req
`endif
);

  function automatic reg_sel_t decode(input logic [31:0] addr);
    if (addr[31:12] != BASE_ADDR[31:12]) return REG_NONE;
    if (addr[11:0] == TOHOST_OFS)        return REG_TOHOST;
    if (addr[11:0] == FHOST_OFS)         return REG_FHOST;
    if (addr[11:0] == STAT_OFS)          return REG_STAT;
    return REG_NONE;
  endfunction

  logic        wr_en;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic [1:0]  wr_resp;
  reg_sel_t    wr_sel;

  cl_mbox_axil_wr u_wr (
    .clk_i     (clk_main_a0),
    .rst_ni    (rst_main_n),
    .awvalid_i (s_awvalid),
    .awready_o (s_awready),
    .awaddr_i  (s_awaddr),
    .wvalid_i  (s_wvalid),
    .wready_o  (s_wready),
    .wdata_i   (s_wdata),
    .wstrb_i   (s_wstrb),
    .bvalid_o  (s_bvalid),
    .bready_i  (s_bready),
    .bresp_o   (s_bresp),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb),
    .wr_resp_i (wr_resp)
  );

  assign wr_sel  = decode(wr_addr);
  assign wr_resp = (wr_sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;

  logic [31:0] tohost_q, tohost_d, fromhost_q, fromhost_d;
  logic [15:0] cnt_q, cnt_d;
  logic        fh_valid_q, fh_valid_d;

  // Core write to TOHOST overrides a colliding host write; the host still sees OKAY.
  always_comb begin
    tohost_d   = tohost_q;
    fromhost_d = fromhost_q;
    fh_valid_d = fh_valid_q;
    cnt_d      = cnt_q;
    if (core_tohost_we)
      tohost_d = core_tohost_wdata;
    else if (wr_en && wr_sel == REG_TOHOST)
      tohost_d = merge_strb(tohost_q, wr_data, wr_strb);
    if (wr_en && wr_sel == REG_FHOST) begin
      fromhost_d = merge_strb(fromhost_q, wr_data, wr_strb);
      fh_valid_d = 1'b1;
    end else if (core_fromhost_ack) begin
      fh_valid_d = 1'b0;
    end
    if (core_tohost_we && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      tohost_q   <= '0;
      fromhost_q <= '0;
      fh_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      tohost_q   <= tohost_d;
      fromhost_q <= fromhost_d;
      fh_valid_q <= fh_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  stat_t       stat;
  reg_sel_t    rd_sel;
  logic [31:0] rd_val;
  logic [1:0]  rd_resp;

  assign stat = '{core_wr_cnt: cnt_q, rsvd: '0, tohost_nz: |tohost_q, fromhost_valid: fh_valid_q};
  assign rd_sel = decode(s_araddr);

  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      REG_TOHOST: rd_val = tohost_q;
      REG_FHOST:  rd_val = fromhost_q;
      REG_STAT:   rd_val = stat;
      default:    rd_resp = RESP_SLVERR;
    endcase
  end

  rd_state_t   rd_state_q;
  logic        arready_q, rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          arready_q <= 1'b1;
          if (s_arvalid && arready_q) begin
            rd_state_q <= RD_DATA;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= rd_val;
            rresp_q    <= rd_resp;
          end
        end
        default: begin
          if (s_rready) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign s_arready           = arready_q;
  assign s_rvalid            = rvalid_q;
  assign s_rdata             = rdata_q;
  assign s_rresp             = rresp_q;
  assign core_tohost_rdata   = tohost_q;
  assign core_fromhost_rdata = fromhost_q;
  assign core_fromhost_valid = fh_valid_q;

`ifdef CL_MBOX_IRQ_EN
  logic irq_q, rd_tohost_q;

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      irq_q       <= 1'b0;
      rd_tohost_q <= 1'b0;
    end else begin
      if (s_arvalid && arready_q) rd_tohost_q <= (rd_sel == REG_TOHOST);
      if (core_tohost_we)
        irq_q <= 1'b1;
      else if (rvalid_q && s_rready && rd_tohost_q)
        irq_q <= 1'b0;
    end
  end

  assign irq_req = irq_q;
`endif

endmodule

// File: tb/tb_cl_tohost_mailbox_slv.sv
// Directed bench for the mailbox responder: host AXI-Lite pokes/peeks, core side strobes, reset abort.
module tb_cl_tohost_mailbox_slv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0, s_arvalid = 1'b0, s_rready = 1'b0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic        core_we = 1'b0, core_ack = 1'b0;
  logic [31:0] core_wdata = '0;
  logic [31:0] core_tohost_rdata, core_fromhost_rdata;
  logic        core_fromhost_valid;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cl_tohost_mailbox_slv dut (
    .clk_main_a0         (clk),
    .rst_main_n          (rst_n),
    .s_awvalid           (s_awvalid),
    .s_awready           (s_awready),
    .s_awaddr            (s_awaddr),
    .s_wvalid            (s_wvalid),
    .s_wready            (s_wready),
    .s_wdata             (s_wdata),
    .s_wstrb             (s_wstrb),
    .s_bvalid            (s_bvalid),
    .s_bready            (s_bready),
    .s_bresp             (s_bresp),
    .s_arvalid           (s_arvalid),
    .s_arready           (s_arready),
    .s_araddr            (s_araddr),
    .s_rvalid            (s_rvalid),
    .s_rready            (s_rready),
    .s_rdata             (s_rdata),
    .s_rresp             (s_rresp),
    .core_tohost_we      (core_we),
    .core_tohost_wdata   (core_wdata),
    .core_tohost_rdata   (core_tohost_rdata),
    .core_fromhost_rdata (core_fromhost_rdata),
    .core_fromhost_valid (core_fromhost_valid),
    .core_fromhost_ack   (core_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AW/W with per-channel start delays; optional core strobes in the first cycle.
  task automatic host_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly,
                           input bit do_core, input logic [31:0] cdat, input bit do_ack);
    bit a_done = 1'b0;
    bit d_done = 1'b0;
    bit a_hs, d_hs;
    for (int c = 0; c < 64 && !(a_done && d_done); c++) begin
      if (!a_done && c >= aw_dly) begin s_awvalid = 1'b1; s_awaddr = addr; end
      if (!d_done && c >= w_dly) begin s_wvalid = 1'b1; s_wdata = data; s_wstrb = strb; end
      if (c == 0) begin core_we = do_core; core_wdata = cdat; core_ack = do_ack; end
      @(negedge clk);
      a_hs = s_awvalid && s_awready;
      d_hs = s_wvalid && s_wready;
      tick();
      core_we = 1'b0;
      core_ack = 1'b0;
      if (a_hs) begin a_done = 1'b1; s_awvalid = 1'b0; end
      if (d_hs) begin d_done = 1'b1; s_wvalid = 1'b0; end
    end
    chk("aw_w_accepted", 32'({a_done, d_done}), 32'h3);
  endtask

  task automatic host_b(input string tag, input logic [1:0] exp_resp);
    int lat = -1;
    for (int c = 0; c < 32; c++) begin
      if (s_bvalid) begin lat = c; break; end
      tick();
    end
    chk({tag, "_blat"}, 32'(lat), 32'd0);
    chk({tag, "_bresp"}, 32'(s_bresp), 32'(exp_resp));
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
  endtask

  task automatic host_rd(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    bit done = 1'b0;
    bit hs;
    s_arvalid = 1'b1;
    s_araddr = addr;
    for (int c = 0; c < 32 && !done; c++) begin
      @(negedge clk);
      hs = s_arvalid && s_arready;
      tick();
      if (hs) begin done = 1'b1; s_arvalid = 1'b0; end
    end
    chk({tag, "_rvalid"}, 32'({done, s_rvalid}), 32'h3);
    chk({tag, "_rdata"}, s_rdata, exp_data);
    chk({tag, "_rresp"}, 32'(s_rresp), 32'(exp_resp));
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
  endtask

  task automatic core_write(input logic [31:0] d);
    core_we = 1'b1;
    core_wdata = d;
    tick();
    core_we = 1'b0;
  endtask

  task automatic core_ack_pulse();
    core_ack = 1'b1;
    tick();
    core_ack = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #2;
    chk("rst_readys", 32'({s_awready, s_wready, s_arready}), 32'h0);
    chk("rst_valids", 32'({s_bvalid, s_rvalid, core_fromhost_valid}), 32'h0);
    chk("rst_resps", 32'({s_bresp, s_rresp}), 32'h0);
    chk("rst_rdata", s_rdata, 32'h0);
    chk("rst_regs", core_tohost_rdata | core_fromhost_rdata, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("idle_readys", 32'({s_awready, s_wready, s_arready}), 32'h7);

    // 1: same-cycle AW/W to TOHOST, then peek
    host_aw_w(32'h0008_C120, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0);
    host_b("t1", 2'b00);
    chk("t1_core_tohost", core_tohost_rdata, 32'hDEAD_BEEF);
    host_rd("t1_peek", 32'h0008_C120, 32'hDEAD_BEEF, 2'b00);

    // 2: core reports pass
    core_write(32'h0);
    host_rd("t2_peek", 32'h0008_C120, 32'h0, 2'b00);
    host_rd("t2_stat", 32'h0008_C160, 32'h0001_0000, 2'b00);

    // 3: W five clocks ahead of AW, then AW ahead of W with B stalled
    host_aw_w(32'h0008_C140, 32'h1234_5678, 4'hF, 5, 0, 1'b0, 32'h0, 1'b0);
    host_b("t3a", 2'b00);
    chk("t3_fromhost", core_fromhost_rdata, 32'h1234_5678);
    host_aw_w(32'h0008_C120, 32'hCAFE_F00D, 4'hF, 0, 3, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_stall", 32'({s_bvalid, s_awready, s_wready}), 32'h4);
      tick();
    end
    host_b("t3b", 2'b00);
    chk("t3_tohost", core_tohost_rdata, 32'hCAFE_F00D);

    // 4: host and core write TOHOST in the same cycle
    host_aw_w(32'h0008_C120, 32'h1111_1111, 4'hF, 0, 0, 1'b1, 32'h2222_2222, 1'b0);
    host_b("t4", 2'b00);
    chk("t4_tohost", core_tohost_rdata, 32'h2222_2222);

    // 5: unmapped / out-of-window, STATUS write, byte strobes
    host_aw_w(32'h0008_C200, 32'h5555_5555, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0);
    host_b("t5_unmap_wr", 2'b10);
    host_aw_w(32'h0009_C120, 32'h6666_6666, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0);
    host_b("t5_oow_wr", 2'b10);
    host_aw_w(32'h0008_C160, 32'hFFFF_FFFF, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0);
    host_b("t5_stat_wr", 2'b00);
    chk("t5_tohost_kept", core_tohost_rdata, 32'h2222_2222);
    chk("t5_fromhost_kept", core_fromhost_rdata, 32'h1234_5678);
    host_rd("t5_unmap_rd", 32'h0008_C200, 32'h0, 2'b10);
    host_rd("t5_oow_rd", 32'h0009_C120, 32'h0, 2'b10);
    host_aw_w(32'h0008_C140, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0);
    host_b("t5_fh_clr", 2'b00);
    host_aw_w(32'h0008_C140, 32'hAABB_CCDD, 4'b0010, 0, 0, 1'b0, 32'h0, 1'b0);
    host_b("t5_fh_strb", 2'b00);
    chk("t5_strb_val", core_fromhost_rdata, 32'h0000_CC00);
    host_rd("t5_stat", 32'h0008_C160, 32'h0002_0003, 2'b00);

    // 6: fromhost_valid handshake, set-over-ack, reset during pending B
    core_ack_pulse();
    chk("t6_ack", 32'(core_fromhost_valid), 32'h0);
    host_aw_w(32'h0008_C140, 32'h0000_0055, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0);
    chk("t6_set", 32'(core_fromhost_valid), 32'h1);
    host_b("t6a", 2'b00);
    core_ack_pulse();
    chk("t6_ack2", 32'(core_fromhost_valid), 32'h0);
    host_aw_w(32'h0008_C140, 32'h0000_0077, 4'hF, 0, 0, 1'b0, 32'h0, 1'b1);
    chk("t6_set_wins", 32'(core_fromhost_valid), 32'h1);
    host_b("t6b", 2'b00);
    host_aw_w(32'h0008_C120, 32'h0000_0099, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0);
    chk("t6_pending_b", 32'(s_bvalid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valids", 32'({s_bvalid, s_rvalid, core_fromhost_valid}), 32'h0);
    chk("t6_rst_readys", 32'({s_awready, s_wready, s_arready}), 32'h0);
    chk("t6_rst_regs", core_tohost_rdata | core_fromhost_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    host_rd("t6_post_stat", 32'h0008_C160, 32'h0, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
